extend_unit: RTL and testbench
==============================

# extend_unit

Registered, parametrised immediate/offset generator for the pipelined MIPS datapath, placed between decode and the ALU/branch stage. It produces zero-extended, sign-extended, upper-immediate, branch-offset, branch-target and jump-target values from instruction fields. Results pass through a 2-entry valid/ready skid buffer so the stage can absorb backpressure. It also supports a synchronous flush for branch squash.

## Interface
Parameters:
- DATA_W, 32, output/PC width; must be ≥ JMP_W+4
- IMM_W, 16, immediate field width; IMM_W < JMP_W
- JMP_W, 26, jump index field width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- Instr  in  JMP_W  instruction bits [JMP_W-1:0]; immediate = Instr[IMM_W-1:0]
- pc_plus4  in  DATA_W  PC+4 of the instruction
- Ext_mode  in  3  operation select
- flush  in  1  synchronous squash of all buffered entries
- out_valid  out  1  Ex_offset/Ex_err valid
- out_ready  in  1  consumer accepts
- Ex_offset  out  DATA_W  result
- Ex_err  out  1  entry carried an illegal Ext_mode

## Operation
- Result is computed combinationally from the inputs at acceptance and stored with its error bit.
- imm = Instr[IMM_W-1:0]; sext = imm sign-extended to DATA_W.
- Ext_mode 0 ZERO: imm zero-extended.
- Ext_mode 1 SIGN: sext.
- Ext_mode 2 UPPER: {imm, (DATA_W-IMM_W) zeros}.
- Ext_mode 3 BTARGET: pc_plus4 + (sext << 2), modulo 2^DATA_W; carry discarded.
- Ext_mode 4 JTARGET: {pc_plus4[DATA_W-1:JMP_W+2], Instr, 2'b00}.
- Ext_mode 5 BOFFS: sext << 2, truncated to DATA_W.
- Ext_mode 6, 7: result 0, Ex_err=1. All legal modes store Ex_err=0.
- Buffer: 2-entry FIFO, count ∈ {0,1,2}. Head drives Ex_offset/Ex_err.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != 2) & rst_n. It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (count != 0).
- count 1, push and pop together: the head is replaced by the new entry and count stays 1.
- count 2, pop: the second entry becomes head and count becomes 1. No push can occur because in_ready=0.
- flush: count becomes 0 at the next edge. Flush beats push and pop in the same cycle, so an input offered that cycle is dropped.
- Reset (asynchronous, any time, including mid-stall):
  - count=0, out_valid=0, Ex_offset=0, Ex_err=0.
  - in_ready=0 while rst_n is low.
  - in_ready=1 in the first cycle after release.
- Storage registers are not cleared by pop or flush. Ex_offset is meaningful only while out_valid=1.

## Timing
- Latency: a request accepted at edge N appears on Ex_offset with out_valid=1 immediately after edge N (visible in cycle N+1).
- Throughput: 1 request/cycle while out_ready=1.
- Ordering is strictly FIFO and no entry is ever duplicated.
- A stall holds up to 2 entries. in_ready drops in the cycle after the second push.
- in_ready recovers in the cycle after the first pop.
- Ex_offset and Ex_err are stable while out_valid=1 and out_ready=0.

## Test plan
- Extension modes, imm=0x8004:
  - mode 0 → 0x00008004
  - mode 1 → 0xFFFF8004
  - mode 2 → 0x80040000
  - mode 5 → 0xFFFE0010
  - Each appears one cycle after acceptance, with Ex_err=0.
- BTARGET:
  - pc_plus4=0x00400010, imm=0xFFFF → 0x0040000C
  - pc_plus4=0xFFFFFFFC, imm=0x0002 → 0x00000004 (wrap)
- JTARGET: pc_plus4=0xA0000004, Instr=0x0100000 → 0xA0400000.
- Backpressure: hold out_ready=0 and offer requests A, B, C back-to-back.
  - A and B are accepted; in_ready goes 0 and C is held.
  - Raise out_ready: outputs A, B, C in order.
  - C is accepted the cycle after A pops.
- Flush:
  - With 2 entries buffered, assert flush together with in_valid=1 → next cycle out_valid=0, count 0, input dropped.
  - A subsequent request flows normally.
- Illegal mode and reset:
  - mode 6 → Ex_offset=0, Ex_err=1.
  - Assert rst_n=0 mid-stall with 2 entries → out_valid=0, Ex_offset=0 and in_ready=0 immediately (asynchronous).
  - After release, in_ready=1.

Source files
------------

// File: rtl/extend_unit.sv
// Immediate/offset generator (zero/sign/upper/branch/jump forms) behind a 2-entry skid buffer.
// Latency 1 cycle; in_ready depends only on registered occupancy; flush empties the buffer.
module extend_unit #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JMP_W  = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [JMP_W-1:0]  Instr,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [2:0]        Ext_mode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Ex_offset,
    output logic              Ex_err
);

    typedef enum logic [2:0] {
        EXT_ZERO    = 3'd0,
        EXT_SIGN    = 3'd1,
        EXT_UPPER   = 3'd2,
        EXT_BTARGET = 3'd3,
        EXT_JTARGET = 3'd4,
        EXT_BOFFS   = 3'd5
    } ext_mode_e;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] val;
    } entry_t;

    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] sext;
    ext_mode_e         mode;
    entry_t            new_entry;

    assign imm  = Instr[IMM_W-1:0];
    assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign mode = ext_mode_e'(Ext_mode);

    always_comb begin
        new_entry.err = 1'b0;
        new_entry.val = '0;
        case (mode)
            EXT_ZERO:    new_entry.val = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_SIGN:    new_entry.val = sext;
            EXT_UPPER:   new_entry.val = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_BTARGET: new_entry.val = pc_plus4 + (sext << 2);
            EXT_JTARGET: new_entry.val = {pc_plus4[DATA_W-1:JMP_W+2], Instr, 2'b00};
            EXT_BOFFS:   new_entry.val = sext << 2;
            default:     new_entry.err = 1'b1;
        endcase
    end

    // head_q always holds the oldest entry so the outputs come straight from a register
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic [1:0] count_mid;
    logic       push, pop;

    assign in_ready  = (count_q != 2'd2) & rst_n;
    assign out_valid = (count_q != 2'd0);
    assign Ex_offset = head_q.val;
    assign Ex_err    = head_q.err;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        count_mid = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_d    = tail_q;
                count_mid = count_q - 2'd1;
            end
            if (push) begin
                if (count_mid == 2'd0) begin
                    head_d = new_entry;
                end else begin
                    tail_d = new_entry;
                end
            end
            count_d = count_mid + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_extend_unit.sv
// Bench for extend_unit: directed cases plus randomized traffic against a queue-based reference.
module tb_extend_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] Instr;
    logic [31:0] pc_plus4;
    logic [2:0]  Ext_mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Ex_offset;
    logic        Ex_err;

    extend_unit #(.DATA_W(32), .IMM_W(16), .JMP_W(26)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Instr     (Instr),
        .pc_plus4  (pc_plus4),
        .Ext_mode  (Ext_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Ex_offset (Ex_offset),
        .Ex_err    (Ex_err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [32:0] q[$];
    logic        accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference result {err, value} derived with plain integer arithmetic.
    function automatic logic [32:0] ref_calc(input logic [2:0] m, input logic [25:0] ins,
                                             input logic [31:0] pc);
        longint imm, s, r;
        logic [63:0] rb;
        imm = longint'(ins) % 65536;
        s   = (imm >= 32768) ? imm - 65536 : imm;
        case (m)
            3'd0: r = imm;
            3'd1: r = s;
            3'd2: r = imm * 65536;
            3'd3: r = longint'(pc) + s * 4;
            3'd4: r = (longint'(pc) / 268435456) * 268435456 + longint'(ins) * 4;
            3'd5: r = s * 4;
            default: return {1'b1, 32'h0};
        endcase
        rb = r;
        return {1'b0, rb[31:0]};
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic        push, pop;
        logic [32:0] nw;
        logic [32:0] hd;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) begin
            hd = q[0];
            chk("ex_offset", Ex_offset, hd[31:0]);
            chk("ex_err", Ex_err, hd[32]);
        end
        push = in_valid && (q.size() < 2);
        pop  = (q.size() != 0) && out_ready;
        nw   = ref_calc(Ext_mode, Instr, pc_plus4);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(nw);
        end
        accepted = push && !flush;
        #1;
    endtask

    task automatic set_req(input logic v, input logic [2:0] m, input logic [25:0] ins,
                           input logic [31:0] pc);
        in_valid = v;
        Ext_mode = m;
        Instr    = ins;
        pc_plus4 = pc;
    endtask

    // Offer a request until it is taken; bounded so a stuck in_ready cannot hang the run.
    task automatic offer(input string tag, input logic [2:0] m, input logic [25:0] ins,
                         input logic [31:0] pc);
        int n = 0;
        set_req(1'b1, m, ins, pc);
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            cycle();
            n++;
        end
        chk({tag, "_accepted"}, accepted, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_req(1'b0, 3'd0, 26'h0, 32'h0);
        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ex_offset", Ex_offset, 32'h0);
        chk("rst_ex_err", Ex_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        offer("zero", 3'd0, 26'h0008004, 32'h0);
        chk("mode0", Ex_offset, 32'h00008004);
        chk("mode0_err", Ex_err, 1'b0);
        offer("sign", 3'd1, 26'h0008004, 32'h0);
        chk("mode1", Ex_offset, 32'hFFFF8004);
        offer("upper", 3'd2, 26'h0008004, 32'h0);
        chk("mode2", Ex_offset, 32'h80040000);
        offer("boffs", 3'd5, 26'h0008004, 32'h0);
        chk("mode5", Ex_offset, 32'hFFFE0010);
        offer("btgt", 3'd3, 26'h000FFFF, 32'h00400010);
        chk("btarget", Ex_offset, 32'h0040000C);
        offer("bwrap", 3'd3, 26'h0000002, 32'hFFFFFFFC);
        chk("btarget_wrap", Ex_offset, 32'h00000004);
        offer("jtgt", 3'd4, 26'h0100000, 32'hA0000004);
        chk("jtarget", Ex_offset, 32'hA0400000);
        offer("illegal", 3'd6, 26'h0001234, 32'h0);
        chk("mode6_val", Ex_offset, 32'h0);
        chk("mode6_err", Ex_err, 1'b1);
        cycle();

        // Backpressure: A, B taken, C held until A leaves.
        out_ready = 1'b0;
        set_req(1'b1, 3'd1, 26'h000000A, 32'h0); cycle();
        chk("bp_a", accepted, 1'b1);
        set_req(1'b1, 3'd1, 26'h000000B, 32'h0); cycle();
        chk("bp_b", accepted, 1'b1);
        set_req(1'b1, 3'd1, 26'h000000C, 32'h0); cycle();
        chk("bp_c_held", accepted, 1'b0);
        cycle();
        chk("bp_c_held2", accepted, 1'b0);
        out_ready = 1'b1;
        cycle();
        chk("bp_c_wait", accepted, 1'b0);
        cycle();
        chk("bp_c_accept", accepted, 1'b1);
        in_valid = 1'b0;
        cycle();
        cycle();
        cycle();

        // Flush with two entries buffered and a request offered.
        out_ready = 1'b0;
        set_req(1'b1, 3'd0, 26'h0000011, 32'h0); cycle();
        set_req(1'b1, 3'd0, 26'h0000022, 32'h0); cycle();
        set_req(1'b1, 3'd0, 26'h0000033, 32'h0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        offer("post_flush", 3'd1, 26'h0000044, 32'h0);
        chk("post_flush_val", Ex_offset, 32'h00000044);
        cycle();

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        set_req(1'b1, 3'd0, 26'h0000055, 32'h0); cycle();
        set_req(1'b1, 3'd0, 26'h0000066, 32'h0); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_ex_offset", Ex_offset, 32'h0);
        chk("arst_ex_err", Ex_err, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cycle();

        // Randomized traffic, stalls and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            set_req($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                    26'($urandom), $urandom);
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 31) == 0;
            cycle();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
